// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the target and the controller.
// State encoding and bus field widths.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam logic [I2C_ADDR_W-1:0] I2C_GEN_CALL_ADDR = 7'h00;
  localparam int I2C_RW_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX,
    S_RX_ACK,
    S_TX,
    S_TX_ACK,
    S_IGNORE
  } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Pad synchroniser, FILTER_LEN-sample glitch filter and edge strobes.
// Pad edge to strobe latency is 2+FILTER_LEN clocks.
module i2c_line_sync #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic reset,
  input  logic i_pad,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW =
    (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_lvl;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Lines idle high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_lvl  <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_pad;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_s2 != r_lvl) begin
        if (r_cnt == LAST) begin
          r_lvl  <= r_s2;
          r_cnt  <= '0;
          r_rise <= r_s2;
          r_fall <= ~r_s2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_lvl;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_target.sv
// I2C 7-bit target, open-drain SDA, no clock stretching.
// Define I2C_GENERAL_CALL_EN to ACK general-call writes.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic                  clk_i,
  input  logic                  reset,
  input  logic [I2C_ADDR_W-1:0] own_addr,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_load,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic                  addressed,
  output logic                  stop_det
);

  logic w_scl_lvl;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_sda_lvl;
  logic w_sda_rise;
  logic w_sda_fall;

  i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk_i   (clk_i),
    .reset   (reset),
    .i_pad   (scl_i),
    .o_level (w_scl_lvl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk_i   (clk_i),
    .reset   (reset),
    .i_pad   (sda_i),
    .o_level (w_sda_lvl),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  i2c_state_t            r_state;
  logic [I2C_BYTE_W-1:0] r_shift;
  logic [3:0]            r_cnt;
  logic                  r_sda_oe;
  logic [I2C_BYTE_W-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_tx_load;
  logic                  r_addressed;
  logic                  r_stop_det;
  logic                  r_rw;
  logic                  r_gc;

  logic                  w_scl_edge;
  logic                  w_start;
  logic                  w_stop;
  logic [I2C_BYTE_W-1:0] w_byte;
  logic                  w_match;
  logic                  w_gc;

  // An SCL edge in the same cycle masks the SDA edge.
  assign w_scl_edge = w_scl_rise | w_scl_fall;
  assign w_start = w_sda_fall & w_scl_lvl & ~w_scl_edge;
  assign w_stop  = w_sda_rise & w_scl_lvl & ~w_scl_edge;
  assign w_byte  = {r_shift[I2C_BYTE_W-2:0], w_sda_lvl};
  assign w_match = w_byte[I2C_BYTE_W-1:1] == own_addr;

`ifdef I2C_GENERAL_CALL_EN
  assign w_gc = w_byte == {I2C_GEN_CALL_ADDR, 1'b0};
`else
  assign w_gc = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_sda_oe    <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_load   <= 1'b0;
      r_addressed <= 1'b0;
      r_stop_det  <= 1'b0;
      r_rw        <= 1'b0;
      r_gc        <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_load  <= 1'b0;
      r_stop_det <= 1'b0;
      // tx_data is captured during the tx_load cycle.
      if (r_tx_load) begin
        r_shift  <= tx_data;
        r_sda_oe <= ~tx_data[I2C_BYTE_W-1];
      end
      if (w_stop) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_sda_oe    <= 1'b0;
        r_addressed <= 1'b0;
        r_stop_det  <= 1'b1;
      end else if (w_start) begin
        r_state     <= S_ADDR;
        r_cnt       <= '0;
        r_shift     <= '0;
        r_sda_oe    <= 1'b0;
        r_addressed <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE, S_IGNORE: begin
            r_sda_oe <= 1'b0;
          end
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              if (r_cnt == 4'd7) begin
                r_cnt <= 4'd8;
                r_rw  <= w_byte[I2C_RW_BIT];
                r_gc  <= ~w_match;
                if (w_match || w_gc) begin
                  r_state <= S_ADDR_ACK;
                end else begin
                  r_state <= S_IGNORE;
                end
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_rise) begin
              r_cnt <= '0;
            end else if (w_scl_fall && r_cnt == 4'd8) begin
              r_sda_oe    <= 1'b1;
              r_addressed <= ~r_gc;
            end else if (w_scl_fall) begin
              if (r_rw) begin
                r_state   <= S_TX;
                r_tx_load <= 1'b1;
              end else begin
                r_state  <= S_RX;
                r_sda_oe <= 1'b0;
              end
            end
          end
          S_RX: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              if (r_cnt == 4'd7) begin
                r_cnt      <= 4'd8;
                r_rx_data  <= w_byte;
                r_rx_valid <= 1'b1;
                r_state    <= S_RX_ACK;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end
          S_RX_ACK: begin
            if (w_scl_rise) begin
              r_cnt <= '0;
            end else if (w_scl_fall && r_cnt == 4'd8) begin
              r_sda_oe <= 1'b1;
            end else if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_state  <= S_RX;
            end
          end
          S_TX: begin
            if (w_scl_rise) begin
              r_cnt <= r_cnt + 4'd1;
            end else if (w_scl_fall && r_cnt == 4'd8) begin
              r_sda_oe <= 1'b0;
              r_state  <= S_TX_ACK;
            end else if (w_scl_fall) begin
              r_shift  <= r_shift << 1;
              r_sda_oe <= ~r_shift[I2C_BYTE_W-2];
            end
          end
          S_TX_ACK: begin
            if (w_scl_rise) begin
              r_cnt <= '0;
              if (w_sda_lvl) begin
                r_state <= S_IGNORE;
              end
            end else if (w_scl_fall && r_cnt == 4'd0) begin
              r_tx_load <= 1'b1;
              r_state   <= S_TX;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign tx_load   = r_tx_load;
  assign addressed = r_addressed;
  assign stop_det  = r_stop_det;

endmodule
